// File: rtl/synth_pkg.sv
// Shared types and widths for the voice divider scheduler.
// Declarations only; no timing or flow control of its own.
package synth_pkg;

    localparam int QUOT_W    = 8;
    localparam int OPERAND_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        WAIT,
        FRAME_DONE
    } sched_state_t;

endpackage

// File: rtl/div_watchdog.sv
// Loadable down-counter guarding one divide: load arms it, dec_i counts, expired_o is high at zero.
// Takes effect on the next edge; clear_i beats load_i, which beats dec_i. It never backpressures.
module div_watchdog #(
    parameter int CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with CYCLES-1 so it reads zero on the CYCLES-th cycle spent waiting.
    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/voice_div_scheduler.sv
// Shares one sequential divider across NUM_VOICES voices, one quotient per voice per sample tick.
// A frame takes NUM_VOICES+1 cycles plus (1 + divider latency) per issued voice; ticks arriving while busy are dropped.
module voice_div_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [OPERAND_W*NUM_VOICES-1:0] count_flat,
    input  logic [OPERAND_W*NUM_VOICES-1:0] divider_flat,
    output logic                           div_start,
    output logic [OPERAND_W-1:0]           div_count,
    output logic [OPERAND_W-1:0]           div_divisor,
    input  logic                           div_done,
    input  logic [QUOT_W-1:0]              div_quotient,
    output logic [QUOT_W*NUM_VOICES-1:0]   quotient_flat,
    output logic                           frame_done,
    output logic                           busy,
    output logic                           overrun,
    output logic                           timeout,
    input  logic                           clear_flags
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    sched_state_t             state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [OPERAND_W-1:0]     count_q, count_d;
    logic [OPERAND_W-1:0]     divisor_q, divisor_d;
    logic [QUOT_W-1:0]        quot_q [NUM_VOICES];
    logic                     overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;

    logic                     quot_we;
    logic [QUOT_W-1:0]        quot_wdat;
    logic                     advance;
    logic                     timeout_set;
    logic                     overrun_set;
    logic                     wd_clear, wd_load, wd_dec, wd_expired;
    logic [OPERAND_W-1:0]     sel_count, sel_divider;

    assign sel_count   = count_flat[idx_q*OPERAND_W +: OPERAND_W];
    assign sel_divider = divider_flat[idx_q*OPERAND_W +: OPERAND_W];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        divisor_d   = divisor_q;
        quot_we     = 1'b0;
        quot_wdat   = '0;
        advance     = 1'b0;
        timeout_set = 1'b0;
        wd_clear    = 1'b0;
        wd_load     = 1'b0;
        wd_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (sample_tick && en) begin
                    idx_d   = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!voice_en[idx_q] || (sel_divider == '0)) begin
                    quot_we = 1'b1;
                    advance = 1'b1;
                end else begin
                    count_d   = sel_count;
                    divisor_d = sel_divider;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    wd_load = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wd_clear = 1'b1;
                if (!en) begin
                    state_d = IDLE;
                end else if (div_done) begin
                    quot_we   = 1'b1;
                    quot_wdat = div_quotient;
                    advance   = 1'b1;
                end else if (wd_expired) begin
                    quot_we     = 1'b1;
                    timeout_set = 1'b1;
                    advance     = 1'b1;
                end else begin
                    wd_clear = 1'b0;
                    wd_dec   = 1'b1;
                end
            end
            FRAME_DONE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = FRAME_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = SELECT;
            end
        end
    end

    // Setting an event outranks a same-cycle clear so no event is ever lost.
    assign overrun_set = sample_tick && en && (state_q != IDLE);
    assign overrun_d   = overrun_set ? 1'b1 : (clear_flags ? 1'b0 : overrun_q);
    assign timeout_d   = timeout_set ? 1'b1 : (clear_flags ? 1'b0 : timeout_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            divisor_q <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                quot_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            divisor_q <= divisor_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            if (quot_we) begin
                quot_q[idx_q] <= quot_wdat;
            end
        end
    end

    div_watchdog #(
        .CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear),
        .load_i    (wd_load),
        .dec_i     (wd_dec),
        .expired_o (wd_expired)
    );

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_quot
        assign quotient_flat[g*QUOT_W +: QUOT_W] = quot_q[g];
    end

    // An abort during ISSUE must not launch a divide whose result nobody will collect.
    assign div_start   = (state_q == ISSUE) && en;
    assign frame_done  = (state_q == FRAME_DONE);
    assign busy        = (state_q != IDLE);
    assign div_count   = count_q;
    assign div_divisor = divisor_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_voice_div_scheduler.sv
// Scoreboarded bench for voice_div_scheduler: directed frames with a behavioural divider.
// Expected div_start operands and frame results are queued at stimulus time and popped by a monitor.
module tb_voice_div_scheduler;

    localparam int NV = 4;
    localparam int WD = 8;

    logic            clk;
    logic            reset;
    logic            en;
    logic            sample_tick;
    logic [NV-1:0]   voice_en;
    logic [16*NV-1:0] count_flat;
    logic [16*NV-1:0] divider_flat;
    logic            div_start;
    logic [15:0]     div_count;
    logic [15:0]     div_divisor;
    logic            div_done;
    logic [7:0]      div_quotient;
    logic [8*NV-1:0] quotient_flat;
    logic            frame_done;
    logic            busy;
    logic            overrun;
    logic            timeout;
    logic            clear_flags;

    voice_div_scheduler #(
        .NUM_VOICES  (NV),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .sample_tick   (sample_tick),
        .voice_en      (voice_en),
        .count_flat    (count_flat),
        .divider_flat  (divider_flat),
        .div_start     (div_start),
        .div_count     (div_count),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .quotient_flat (quotient_flat),
        .frame_done    (frame_done),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout),
        .clear_flags   (clear_flags)
    );

    typedef struct {
        bit          is_frame;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] q;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   dm_en = 1'b1;
    int   dm_lat = 3;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_start(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.is_frame = 1'b0; e.a = a; e.b = b; e.q = '0; e.cyc = -1;
        sbq.push_back(e);
    endtask

    task automatic push_frame(input logic [31:0] q, input int c);
        exp_t e;
        e.is_frame = 1'b1; e.a = '0; e.b = '0; e.q = q; e.cyc = c;
        sbq.push_back(e);
    endtask

    // Monitor: every div_start / frame_done must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (div_start) begin
            if (sbq.size() == 0) begin
                chk("unexpected_div_start", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("start_kind", e.is_frame, 0);
                chk("start_count", div_count, e.a);
                chk("start_divisor", div_divisor, e.b);
            end
        end
        if (frame_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_frame_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("frame_kind", e.is_frame, 1);
                chk("frame_quotients", quotient_flat, e.q);
                if (e.cyc >= 0) chk("frame_cycle", cyc, e.cyc);
            end
        end
    end

    // Behavioural divider: answers dm_lat cycles after a start pulse.
    initial begin : divider_model
        logic [15:0] a, b;
        int lat;
        div_done = 1'b0;
        div_quotient = '0;
        forever begin
            @(negedge clk);
            if (div_start && dm_en) begin
                a = div_count; b = div_divisor; lat = dm_lat;
                repeat (lat) @(posedge clk);
                #1;
                div_done = 1'b1;
                div_quotient = 8'(a / b);
                @(posedge clk);
                #1;
                div_done = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_tick(output int t0);
        sample_tick = 1'b1;
        t0 = cyc;
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic set_voice(input int i, input logic on, input logic [15:0] c, input logic [15:0] d);
        voice_en[i] = on;
        count_flat[16*i +: 16] = c;
        divider_flat[16*i +: 16] = d;
    endtask

    task automatic clear_voices();
        voice_en = '0;
        count_flat = '0;
        divider_flat = '0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
        chk({"drain_", name}, sbq.size(), 0);
        step(2);
        chk({"idle_after_", name}, busy, 0);
    endtask

    task automatic wait_start(input int n, input string name);
        int seen = 0;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(negedge clk);
            if (div_start) seen++;
        end
        chk({"start_seen_", name}, seen, n);
    endtask

    initial begin : main
        int t0;
        reset = 1'b1; en = 1'b1; sample_tick = 1'b0; clear_flags = 1'b0;
        clear_voices();
        step(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_quotients", quotient_flat, 0);
        chk("rst_flags", {overrun, timeout}, 0);
        chk("rst_operands", {div_count, div_divisor}, 0);
        step(1);

        // All voices disabled: frame_done five cycles after the tick.
        set_voice(0, 1'b0, 16'd123, 16'd7);
        set_voice(1, 1'b0, 16'd55, 16'd5);
        push_frame(32'h0, cyc + 5);
        issue_tick(t0);
        wait_drain("all_skipped");

        // Voices 0 and 2 through the divider, three-cycle latency.
        clear_voices();
        set_voice(0, 1'b1, 16'd300, 16'd100);
        set_voice(2, 1'b1, 16'd50, 16'd200);
        set_voice(3, 1'b1, 16'd77, 16'd0);
        push_start(16'd300, 16'd100);
        push_start(16'd50, 16'd200);
        push_frame(32'h0000_0003, cyc + 13);
        issue_tick(t0);
        wait_drain("two_voices");

        // Seed voice 1 with a nonzero result, then let the watchdog abandon it.
        clear_voices();
        set_voice(1, 1'b1, 16'd1000, 16'd10);
        push_start(16'd1000, 16'd10);
        push_frame(32'h0000_6400, -1);
        issue_tick(t0);
        wait_drain("seed_v1");
        dm_en = 1'b0;
        push_start(16'd1000, 16'd10);
        push_frame(32'h0000_0000, -1);
        issue_tick(t0);
        wait_drain("timeout_frame");
        chk("timeout_set", timeout, 1);
        chk("overrun_quiet", overrun, 0);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        chk("timeout_cleared", timeout, 0);

        // div_done on the very cycle the watchdog expires wins.
        dm_en = 1'b1;
        dm_lat = WD;
        clear_voices();
        set_voice(3, 1'b1, 16'd900, 16'd100);
        push_start(16'd900, 16'd100);
        push_frame(32'h0900_0000, -1);
        issue_tick(t0);
        wait_drain("done_at_expiry");
        chk("no_timeout_at_expiry", timeout, 0);
        dm_lat = 3;

        // Second tick during WAIT, together with clear_flags.
        clear_voices();
        set_voice(0, 1'b1, 16'd300, 16'd100);
        push_start(16'd300, 16'd100);
        push_frame(32'h0000_0003, -1);
        issue_tick(t0);
        step(2);
        sample_tick = 1'b1; clear_flags = 1'b1;
        step(1);
        sample_tick = 1'b0; clear_flags = 1'b0;
        chk("overrun_beats_clear", overrun, 1);
        wait_drain("overrun_frame");
        chk("overrun_sticky", overrun, 1);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // en drops during voice 2's WAIT; its late result must be ignored.
        clear_voices();
        set_voice(0, 1'b1, 16'd40, 16'd10);
        set_voice(1, 1'b1, 16'd60, 16'd20);
        set_voice(2, 1'b1, 16'd100, 16'd1);
        push_start(16'd40, 16'd10);
        push_start(16'd60, 16'd20);
        push_start(16'd100, 16'd1);
        issue_tick(t0);
        wait_start(2, "v1");
        step(1);
        dm_lat = 6;
        wait_start(1, "v2");
        step(1);
        en = 1'b0;
        step(1);
        chk("abort_busy", busy, 0);
        step(10);
        chk("abort_quotients", quotient_flat, 32'h0000_0304);
        chk("abort_no_frame", sbq.size(), 0);
        chk("abort_busy_late", busy, 0);
        en = 1'b1;
        dm_lat = 3;

        // Reset during ISSUE, with an overrun pending.
        clear_voices();
        set_voice(0, 1'b1, 16'd300, 16'd100);
        push_start(16'd300, 16'd100);
        issue_tick(t0);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        wait_start(1, "pre_reset");
        chk("pre_reset_overrun", overrun, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_outputs", {div_start, frame_done, overrun, timeout}, 0);
        chk("mid_rst_operands", {div_count, div_divisor}, 0);
        chk("mid_rst_quotients", quotient_flat, 0);
        step(1);
        reset = 1'b0;
        step(6);
        push_start(16'd300, 16'd100);
        push_frame(32'h0000_0003, cyc + 9);
        issue_tick(t0);
        wait_drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : global_guard
        #400000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected to have finished", cyc);
        $fatal(1);
    end

endmodule
